// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns hazard, stall, redirect and interrupt
// requests into one prioritised hold/flush/jump command per cycle.
module pipe_ctrl #(
  parameter int REDIR_CYCLES  = 2,
  parameter int MULTI_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_raddr_i,
  input  logic [4:0]  id_rs2_raddr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        ex_is_load_i,
  input  logic        ex_reg_we_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_start_i,
  input  logic        div_done_i,
  input  logic        bus_hold_i,
  input  logic        int_req_i,
  input  logic [31:0] int_addr_i,
  output logic [2:0]  hold_flag_o,
  output logic [1:0]  flush_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        int_ack_o,
  output logic [31:0] stall_cycles_o,
  output logic        stall_timeout_o
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_REDIR = 2'd1;
  localparam logic [1:0] S_MULTI = 2'd2;

  localparam logic [2:0] H_NONE = 3'd0;
  localparam logic [2:0] H_ID   = 3'd3;
  localparam logic [2:0] H_EX   = 3'd4;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_ID   = 2'd2;
  localparam logic [1:0] F_EX   = 2'd3;

  localparam logic [3:0] REDIR_LD = 4'(REDIR_CYCLES);
  localparam logic [7:0] TMO      = 8'(MULTI_TIMEOUT);

  // With no flush window a redirect goes straight back to RUN.
  localparam logic [1:0] S_AFTER =
    (REDIR_CYCLES == 0) ? S_RUN : S_REDIR;

  logic [1:0]  state_q, state_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [7:0]  mcnt_q, mcnt_d;
  logic        tmo_q, tmo_d;
  logic [31:0] stall_q;

  logic [2:0]  hold;
  logic [1:0]  flush;
  logic        jflag;
  logic [31:0] jaddr;
  logic        ack;
  logic        load_use;

  assign load_use = ex_is_load_i & ex_reg_we_i
                  & (ex_reg_waddr_i != 5'd0)
                  & ((id_rs1_used_i
                      & (id_rs1_raddr_i == ex_reg_waddr_i))
                   | (id_rs2_used_i
                      & (id_rs2_raddr_i == ex_reg_waddr_i)));

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    mcnt_d  = mcnt_q;
    tmo_d   = tmo_q;
    hold    = H_NONE;
    flush   = F_NONE;
    jflag   = 1'b0;
    jaddr   = 32'd0;
    ack     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (int_req_i && !bus_hold_i) begin
          jflag   = 1'b1;
          jaddr   = int_addr_i;
          flush   = F_EX;
          ack     = 1'b1;
          rcnt_d  = REDIR_LD;
          state_d = S_AFTER;
        end else if (jump_req_i) begin
          jflag   = 1'b1;
          jaddr   = jump_addr_i;
          flush   = F_EX;
          rcnt_d  = REDIR_LD;
          state_d = S_AFTER;
        end else if (div_start_i) begin
          hold    = H_EX;
          mcnt_d  = 8'd0;
          state_d = S_MULTI;
        end else if (bus_hold_i) begin
          hold = H_EX;
        end else if (load_use) begin
          hold = H_ID;
        end
      end
      S_REDIR: begin
        if (jump_req_i) begin
          jflag   = 1'b1;
          jaddr   = jump_addr_i;
          flush   = F_EX;
          rcnt_d  = REDIR_LD;
          state_d = S_AFTER;
        end else begin
          flush = F_ID;
          if (bus_hold_i) begin
            hold = H_EX;
          end else if (rcnt_q <= 4'd1) begin
            rcnt_d  = 4'd0;
            state_d = S_RUN;
          end else begin
            rcnt_d = rcnt_q - 4'd1;
          end
        end
      end
      S_MULTI: begin
        if (div_done_i) begin
          state_d = S_RUN;
        end else begin
          hold = H_EX;
          if (mcnt_q != 8'hff) begin
            mcnt_d = mcnt_q + 8'd1;
          end
          if (mcnt_d >= TMO) begin
            tmo_d = 1'b1;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      rcnt_q  <= 4'd0;
      mcnt_q  <= 8'd0;
      tmo_q   <= 1'b0;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      mcnt_q  <= mcnt_d;
      tmo_q   <= tmo_d;
      if (hold != H_NONE) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  // Combinational command is forced quiet while reset is held.
  assign hold_flag_o     = rst ? hold  : H_NONE;
  assign flush_flag_o    = rst ? flush : F_NONE;
  assign jump_flag_o     = rst & jflag;
  assign jump_addr_o     = rst ? jaddr : 32'd0;
  assign int_ack_o       = rst & ack;
  assign stall_cycles_o  = stall_q;
  assign stall_timeout_o = tmo_q;

endmodule
